// File: rtl/pong_defs_pkg.sv
// Shared pong definitions: FSM state encodings, screen extents and toss-bit meanings.
`default_nettype none
package pong_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam int MAX_X = 639;
  localparam int MAX_Y = 479;

  // next_toss[1]=1: x velocity toward left; next_toss[0]=1: y velocity upward
  localparam int TOSS_X_NEG_BIT = 1;
  localparam int TOSS_Y_NEG_BIT = 0;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5 on reset.
`default_nettype none
module pong_lfsr8 (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] q
);

  logic feedback;
  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 8'hA5;
    else          q <= {q[6:0], feedback};
  end

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve hold, toss direction, score keeping and match end.
`default_nettype none
module pong_game_ctrl
  import pong_defs::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 120,
  parameter int OVER_TICKS  = 180
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       refr_tick,
  input  logic [3:0] btn,
  input  logic       left_miss,
  input  logic       right_miss,
  output logic       gra_still,
  output logic [1:0] next_toss,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       winner
);

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_TICKS - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_TICKS - 1);
  localparam logic [3:0] WIN4       = 4'(WIN_SCORE);

  state_t     state;
  logic [7:0] timer;
  logic [3:0] btn_prev;
  logic [7:0] lfsr;
  logic [3:0] score_l_inc;
  logic [3:0] score_r_inc;
  logic       press_edge;
  logic       unused_lfsr_bits;

  pong_lfsr8 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[6:1];
  assign score_l_inc      = sat_inc4(score_l);
  assign score_r_inc      = sat_inc4(score_r);
  assign press_edge       = (btn != 4'd0) && (btn_prev == 4'd0);
  assign gra_still        = (state != ST_PLAY);
  assign game_state       = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      next_toss <= 2'b00;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      winner    <= 1'b0;
      timer     <= 8'd0;
      btn_prev  <= 4'hF;
    end else begin
      btn_prev <= btn;
      case (state)
        ST_IDLE: begin
          if (press_edge) begin
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            winner    <= 1'b0;
            next_toss <= {lfsr[7], lfsr[0]};
            timer     <= 8'd0;
            state     <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (refr_tick) begin
            if (timer == SERVE_LAST) state <= ST_PLAY;
            else                     timer <= timer + 8'd1;
          end
        end
        ST_PLAY: begin
          // Left miss wins a tie; the serve heads toward whoever missed.
          if (left_miss) begin
            score_r   <= score_r_inc;
            next_toss <= {1'b1, lfsr[0]};
            timer     <= 8'd0;
            if (score_r_inc == WIN4) begin
              winner <= 1'b0;
              state  <= ST_OVER;
            end else begin
              state  <= ST_SERVE;
            end
          end else if (right_miss) begin
            score_l   <= score_l_inc;
            next_toss <= {1'b0, lfsr[0]};
            timer     <= 8'd0;
            if (score_l_inc == WIN4) begin
              winner <= 1'b1;
              state  <= ST_OVER;
            end else begin
              state  <= ST_SERVE;
            end
          end
        end
        ST_OVER: begin
          if (refr_tick) begin
            if (timer == OVER_LAST) state <= ST_IDLE;
            else                    timer <= timer + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl with default parameters.
`default_nettype none
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       refr_tick = 1'b0;
  logic [3:0] btn = 4'b0001;
  logic       left_miss = 1'b0;
  logic       right_miss = 1'b0;
  logic       gra_still;
  logic [1:0] next_toss;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] game_state;
  logic       winner;

  int total  = 0;
  int passed = 0;
  logic [7:0] m_lfsr;
  logic [7:0] snap;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .refr_tick  (refr_tick),
    .btn        (btn),
    .left_miss  (left_miss),
    .right_miss (right_miss),
    .gra_still  (gra_still),
    .next_toss  (next_toss),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_state (game_state),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 8,6,5,4, seed A5
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_still"}, gra_still, 1);
    chk({tag, "_toss"}, next_toss, 0);
    chk({tag, "_sl"}, score_l, 0);
    chk({tag, "_sr"}, score_r, 0);
    chk({tag, "_win"}, winner, 0);
  endtask

  task automatic serve();
    refr_tick = 1'b1;
    step(120);
    refr_tick = 1'b0;
    chk("serve_play", game_state, 2);
  endtask

  task automatic right_point();
    right_miss = 1'b1;
    snap = m_lfsr;
    step(1);
    right_miss = 1'b0;
    chk("rmiss_toss", next_toss, {1'b0, snap[0]});
  endtask

  initial begin
    step(3);
    check_reset_vals("rst");
    reset_n = 1'b1;
    step(3);
    chk("held_btn_idle", game_state, 0);

    btn = 4'b0000;
    step(1);
    btn = 4'b0100;
    snap = m_lfsr;
    step(1);
    btn = 4'b0000;
    chk("start_state", game_state, 1);
    chk("start_still", gra_still, 1);
    chk("start_sl", score_l, 0);
    chk("start_sr", score_r, 0);
    chk("start_toss", next_toss, {snap[7], snap[0]});

    refr_tick = 1'b1;
    step(119);
    chk("serve_119", game_state, 1);
    chk("serve_119_still", gra_still, 1);
    step(1);
    refr_tick = 1'b0;
    chk("serve_120", game_state, 2);
    chk("serve_120_still", gra_still, 0);

    left_miss = 1'b1;
    refr_tick = 1'b1;
    snap = m_lfsr;
    step(1);
    refr_tick = 1'b0;
    chk("lmiss_sr", score_r, 1);
    chk("lmiss_state", game_state, 1);
    chk("lmiss_still", gra_still, 1);
    chk("lmiss_toss", next_toss, {1'b1, snap[0]});
    step(2);
    left_miss = 1'b0;
    chk("lmiss_once", score_r, 1);

    serve();
    left_miss = 1'b1;
    right_miss = 1'b1;
    step(1);
    left_miss = 1'b0;
    right_miss = 1'b0;
    chk("both_sr", score_r, 2);
    chk("both_sl", score_l, 0);

    for (int i = 0; i < 6; i++) begin
      serve();
      right_point();
    end
    chk("six_sl", score_l, 6);
    chk("six_state", game_state, 1);

    serve();
    right_point();
    chk("win_sl", score_l, 7);
    chk("win_state", game_state, 3);
    chk("win_winner", winner, 1);
    chk("win_still", gra_still, 1);

    refr_tick = 1'b1;
    step(179);
    chk("over_179", game_state, 3);
    step(1);
    refr_tick = 1'b0;
    chk("over_idle", game_state, 0);
    chk("over_sl_held", score_l, 7);
    chk("over_sr_held", score_r, 2);
    chk("over_win_held", winner, 1);

    btn = 4'b1000;
    step(1);
    btn = 4'b0000;
    chk("restart_state", game_state, 1);
    chk("restart_sl", score_l, 0);
    chk("restart_sr", score_r, 0);
    chk("restart_win", winner, 0);

    for (int i = 0; i < 3; i++) begin
      serve();
      right_point();
    end
    serve();
    chk("mid_sl", score_l, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    step(2);
    reset_n = 1'b1;
    step(2);
    chk("midrst_idle", game_state, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
